// File: rtl/eth_mii_rx.sv
// MII receive deframer: strips preamble/SFD, assembles bytes, checks FCS and frame length.
// Latency: byte out one cycle after its high nibble, status one cycle after RXDV falls; no backpressure.
module eth_mii_rx #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [3:0]  ETH_RXD,
    input  logic        ETH_RXDV,
    input  logic        ETH_RXER,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_crc_ok,
    output logic        rx_err,
    output logic [10:0] rx_len,
    output logic        rx_busy
);
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_PRE  = 2'd1;
    localparam logic [1:0]  S_DATA = 2'd2;
    localparam logic [1:0]  S_DROP = 2'd3;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] MIN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L = 11'(MAX_LEN);
    localparam logic [10:0] LEN_SAT = 11'h7FF;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = {1'b0, r[31:1]} ^ 32'hEDB88320;
            else             r = {1'b0, r[31:1]};
        end
        return r;
    endfunction

    logic [1:0]  state_q, state_d;
    logic        phase_q, phase_d;
    logic [3:0]  low_q, low_d;
    logic [31:0] crc_q, crc_d;
    logic [10:0] cnt_q, cnt_d;
    logic        first_q, first_d;
    logic        rxer_seen_q, rxer_seen_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        crc_ok_q, crc_ok_d;
    logic        err_q, err_d;
    logic [10:0] len_q, len_d;
    logic [7:0]  byte_c;
    logic        crc_good_c;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        low_d       = low_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        rxer_seen_d = rxer_seen_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        crc_ok_d    = crc_ok_q;
        err_d       = err_q;
        len_d       = len_q;
        byte_c      = {ETH_RXD, low_q};
        crc_good_c  = (crc_q == CRC_RESIDUE);

        case (state_q)
            S_IDLE: if (ETH_RXDV) state_d = S_PRE;
            S_PRE: begin
                if (!ETH_RXDV)            state_d = S_IDLE;
                else if (ETH_RXER)        state_d = S_DROP;
                else if (ETH_RXD == 4'h5) state_d = S_PRE;
                else if (ETH_RXD == 4'hD) begin
                    state_d     = S_DATA;
                    phase_d     = 1'b0;
                    crc_d       = 32'hFFFFFFFF;
                    cnt_d       = 11'd0;
                    first_d     = 1'b1;
                    rxer_seen_d = 1'b0;
                end
                else                      state_d = S_DROP;
            end
            S_DATA: begin
                if (!ETH_RXDV) begin
                    // Status is taken from the registered state, which already includes the last byte.
                    state_d  = S_IDLE;
                    eof_d    = 1'b1;
                    crc_ok_d = crc_good_c;
                    err_d    = !crc_good_c || rxer_seen_q || phase_q ||
                               (cnt_q < MIN_L) || (cnt_q > MAX_L);
                    len_d    = cnt_q;
                end else begin
                    if (ETH_RXER) rxer_seen_d = 1'b1;
                    if (!phase_q) begin
                        low_d   = ETH_RXD;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        data_d  = byte_c;
                        valid_d = 1'b1;
                        sof_d   = first_q;
                        first_d = 1'b0;
                        crc_d   = crc_byte(crc_q, byte_c);
                        if (cnt_q != LEN_SAT) cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            default: if (!ETH_RXDV) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            low_q       <= 4'd0;
            crc_q       <= 32'd0;
            cnt_q       <= 11'd0;
            first_q     <= 1'b0;
            rxer_seen_q <= 1'b0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            crc_ok_q    <= 1'b0;
            err_q       <= 1'b0;
            len_q       <= 11'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            low_q       <= low_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            rxer_seen_q <= rxer_seen_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            crc_ok_q    <= crc_ok_d;
            err_q       <= err_d;
            len_q       <= len_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_sof    = sof_q;
    assign rx_eof    = eof_q;
    assign rx_crc_ok = crc_ok_q;
    assign rx_err    = err_q;
    assign rx_len    = len_q;
    assign rx_busy   = (state_q != S_IDLE);
endmodule

// File: tb/tb_eth_mii_rx.sv
// Directed bench for eth_mii_rx: expected bytes and end-of-frame status are queued as frames are driven.
module tb_eth_mii_rx;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic [3:0]  ETH_RXD;
    logic        ETH_RXDV;
    logic        ETH_RXER;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err, rx_busy;
    logic [10:0] rx_len;

    always #5 CLK = ~CLK;

    eth_mii_rx #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .CLK(CLK), .RSTN(RSTN), .ETH_RXD(ETH_RXD), .ETH_RXDV(ETH_RXDV), .ETH_RXER(ETH_RXER),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
        .rx_crc_ok(rx_crc_ok), .rx_err(rx_err), .rx_len(rx_len), .rx_busy(rx_busy)
    );

    typedef struct packed { logic [7:0] d; logic sof; } bexp_t;
    typedef struct packed { logic crc_ok; logic err; logic [10:0] len; } sexp_t;

    bexp_t      exp_q[$];
    sexp_t      st_q[$];
    logic [7:0] frm[$];
    sexp_t      last_st;
    bexp_t      mon_b;
    sexp_t      mon_s;
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge CLK) begin
        if (rx_valid === 1'b1) begin
            chk("byte_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_b = exp_q.pop_front();
                chk("byte_data", 32'(rx_data), 32'(mon_b.d));
                chk("byte_sof", 32'(rx_sof), 32'(mon_b.sof));
            end
        end
        if (rx_eof === 1'b1) begin
            chk("eof_valid_low", 32'(rx_valid), 32'd0);
            chk("eof_expected", 32'(st_q.size() > 0), 32'd1);
            if (st_q.size() > 0) begin
                mon_s = st_q.pop_front();
                chk("eof_crc_ok", 32'(rx_crc_ok), 32'(mon_s.crc_ok));
                chk("eof_err", 32'(rx_err), 32'(mon_s.err));
                chk("eof_len", 32'(rx_len), 32'(mon_s.len));
            end
        end
    end

    task automatic drive(input logic [3:0] d, input logic dv, input logic er);
        @(posedge CLK);
        #1;
        ETH_RXD  = d;
        ETH_RXDV = dv;
        ETH_RXER = er;
    endtask

    // Non-reflected MSB-first CRC over bit-reversed bytes, then reflected and complemented into the FCS.
    function automatic logic [31:0] calc_fcs();
        logic [31:0] c;
        logic [31:0] r;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (frm[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[31] ^ frm[i][b];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C11DB7;
            end
        end
        for (int k = 0; k < 32; k++) r[k] = c[31-k];
        return ~r;
    endfunction

    task automatic build(input int npay, input int seed);
        logic [31:0] f;
        frm.delete();
        for (int i = 0; i < npay; i++) frm.push_back(8'(i * 37 + 11 + seed));
        f = calc_fcs();
        for (int k = 0; k < 4; k++) frm.push_back(f[8*k +: 8]);
    endtask

    task automatic preamble();
        for (int k = 0; k < 15; k++) drive(4'h5, 1'b1, 1'b0);
        drive(4'hD, 1'b1, 1'b0);
    endtask

    task automatic send_frame(input int er_at, input bit extra, input bit crc_good);
        sexp_t s;
        bexp_t b;
        int    n;
        n        = frm.size();
        s.len    = (n > 2047) ? 11'h7FF : 11'(n);
        s.crc_ok = crc_good;
        s.err    = !crc_good || (er_at >= 0) || extra || (n < MIN_LEN) || (n > MAX_LEN);
        st_q.push_back(s);
        last_st = s;
        preamble();
        for (int i = 0; i < n; i++) begin
            b.d   = frm[i];
            b.sof = (i == 0);
            exp_q.push_back(b);
            drive(frm[i][3:0], 1'b1, i == er_at);
            drive(frm[i][7:4], 1'b1, i == er_at);
        end
        if (extra) drive(4'hA, 1'b1, 1'b0);
        drive(4'h0, 1'b0, 1'b0);
    endtask

    task automatic settle(input string tag);
        repeat (4) @(negedge CLK);
        chk({tag, "_bytes_drained"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_eofs_drained"}, 32'(st_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        RSTN = 1'b0; ETH_RXD = 4'h5; ETH_RXDV = 1'b1; ETH_RXER = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_sof", 32'(rx_sof), 32'd0);
        chk("rst_eof", 32'(rx_eof), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_crc_ok", 32'(rx_crc_ok), 32'd0);
        chk("rst_err", 32'(rx_err), 32'd0);
        chk("rst_len", 32'(rx_len), 32'd0);
        chk("rst_busy", 32'(rx_busy), 32'd0);
        @(posedge CLK); #1;
        RSTN = 1'b1; ETH_RXDV = 1'b0; ETH_RXER = 1'b0;
        repeat (2) drive(4'h0, 1'b0, 1'b0);

        // Good 64-byte frame, then hold of status.
        build(60, 0);
        send_frame(-1, 1'b0, 1'b1);
        settle("good");
        repeat (5) @(negedge CLK);
        chk("hold_len", 32'(rx_len), 32'(last_st.len));
        chk("hold_crc_ok", 32'(rx_crc_ok), 32'(last_st.crc_ok));
        chk("hold_err", 32'(rx_err), 32'(last_st.err));

        // Bit 3 of byte 10 flipped after the FCS was computed.
        build(60, 0);
        frm[10] = frm[10] ^ 8'h08;
        send_frame(-1, 1'b0, 1'b0);
        settle("badcrc");

        // Fifth preamble nibble is 0x3: whole frame dropped.
        build(60, 3);
        for (int k = 0; k < 4; k++) drive(4'h5, 1'b1, 1'b0);
        drive(4'h3, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) drive(4'h5, 1'b1, 1'b0);
        drive(4'hD, 1'b1, 1'b0);
        foreach (frm[i]) begin
            drive(frm[i][3:0], 1'b1, 1'b0);
            drive(frm[i][7:4], 1'b1, 1'b0);
        end
        drive(4'h0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("drop_busy_still_high", 32'(rx_busy), 32'd1);
        @(negedge CLK);
        chk("drop_busy_low", 32'(rx_busy), 32'd0);
        settle("drop");
        chk("drop_len_held", 32'(rx_len), 32'(last_st.len));
        chk("drop_err_held", 32'(rx_err), 32'(last_st.err));

        // Trailing nibble, then back-to-back frame with RXER at byte 20.
        build(60, 5);
        send_frame(-1, 1'b1, 1'b1);
        build(60, 9);
        send_frame(20, 1'b0, 1'b1);
        settle("b2b");

        // Runt and oversize frames.
        build(26, 1);
        send_frame(-1, 1'b0, 1'b1);
        settle("runt");
        build(1596, 2);
        send_frame(-1, 1'b0, 1'b1);
        settle("giant");

        // Reset pulse at byte 30 abandons the frame; a good frame follows.
        build(60, 0);
        preamble();
        for (int i = 0; i < 30; i++) begin
            mon_b.d = frm[i]; mon_b.sof = (i == 0);
            exp_q.push_back(mon_b);
            drive(frm[i][3:0], 1'b1, 1'b0);
            drive(frm[i][7:4], 1'b1, 1'b0);
        end
        @(posedge CLK); #1;
        RSTN = 1'b0; ETH_RXD = frm[30][3:0]; ETH_RXDV = 1'b1;
        @(posedge CLK); #1;
        RSTN = 1'b1; ETH_RXD = frm[30][7:4];
        @(negedge CLK);
        chk("midrst_len", 32'(rx_len), 32'd0);
        chk("midrst_busy", 32'(rx_busy), 32'd0);
        chk("midrst_eof", 32'(rx_eof), 32'd0);
        for (int i = 31; i < 64; i++) begin
            drive(frm[i][3:0], 1'b1, 1'b0);
            drive(frm[i][7:4], 1'b1, 1'b0);
        end
        repeat (12) drive(4'h0, 1'b0, 1'b0);
        settle("midrst");
        build(60, 4);
        send_frame(-1, 1'b0, 1'b1);
        settle("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
